// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard control slice of the
// 5-stage RV32I pipeline: operand-select codes, FSM state encoding and
// default widths.
package fwd_hazard_unit_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 32;

    // EX operand MUX select codes; 2'b11 is reserved and never driven.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the hazard unit: ID-stage operand/destination
// information, branch and data-memory status in; operand selects, stall,
// flush and freeze controls out.
// master = pipeline datapath, slave = fwd_hazard_unit.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_memop;
    logic                  ex_branch_taken;
    logic                  dmem_ready;

    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  pc_write_en;
    logic                  id_ex_flush;
    logic                  if_id_flush;
    logic                  pipe_freeze;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memop, ex_branch_taken, dmem_ready,
        input  fwd_a_sel, fwd_b_sel, pc_write_en, id_ex_flush, if_id_flush,
               pipe_freeze
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memop, ex_branch_taken, dmem_ready,
        output fwd_a_sel, fwd_b_sel, pc_write_en, id_ex_flush, if_id_flush,
               pipe_freeze
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// fwd_match: combinational forwarding decision for one EX operand.
// Looks at the instructions currently in EX and MEM (which will sit in MEM
// and WB when the ID instruction reaches EX); the younger EX producer wins.
// x0 is never forwarded.
module fwd_match
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic                  mem_valid,
    output logic [1:0]            sel
);

    logic ex_hit_s;
    logic mem_hit_s;

    assign ex_hit_s  = ex_valid & ex_regwrite & (ex_rd != {REG_ADDR_W{1'b0}})
                     & (ex_rd == rs) & use_rs;
    assign mem_hit_s = mem_valid & mem_regwrite & (mem_rd != {REG_ADDR_W{1'b0}})
                     & (mem_rd == rs) & use_rs;

    // Priority pick: EX result first, then MEM/WB value, else register file.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit_s) begin
            sel = FWD_MEM;
        end else if (mem_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and hazard control for the 5-stage RV32I pipe.
// Tracks EX/MEM/WB destination metadata, registers the EX operand selects on
// the ID->EX advance, and decodes load-use stall, data-memory wait freeze and
// branch flush controls (combinational, priority reset > wait > branch > stall).
// Optional build macro HAZARD_STATS_EN adds a saturating stall_count output.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    fwd_hazard_unit_if.slave bus
);

    // Per-stage metadata
    logic                  ex_valid_r, ex_regwrite_r, ex_memread_r, ex_memop_r;
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  mem_valid_r, mem_regwrite_r, mem_memop_r;
    logic [REG_ADDR_W-1:0] mem_rd_r;
    logic                  wb_valid_r, wb_regwrite_r;
    logic [REG_ADDR_W-1:0] wb_rd_r;

    hz_state_e             state_r, state_nxt_s;
    logic [1:0]            fwd_a_r, fwd_b_r, fwd_a_s, fwd_b_s;
    logic                  freeze_s, load_hazard_s, stall_s, bubble_s;
    logic                  pc_write_en_s, id_ex_flush_s, if_id_flush_s, pipe_freeze_s;

    // WB metadata is kept for completeness of the stage picture; the register
    // file write-through covers that distance, so nothing consumes it here.
    logic                  unused_wb_s;
    assign unused_wb_s = ^{wb_valid_r, wb_regwrite_r, wb_rd_r};

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .rs           (bus.id_rs1),
        .use_rs       (bus.id_use_rs1),
        .ex_rd        (ex_rd_r),
        .ex_regwrite  (ex_regwrite_r),
        .ex_valid     (ex_valid_r),
        .mem_rd       (mem_rd_r),
        .mem_regwrite (mem_regwrite_r),
        .mem_valid    (mem_valid_r),
        .sel          (fwd_a_s)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .rs           (bus.id_rs2),
        .use_rs       (bus.id_use_rs2),
        .ex_rd        (ex_rd_r),
        .ex_regwrite  (ex_regwrite_r),
        .ex_valid     (ex_valid_r),
        .mem_rd       (mem_rd_r),
        .mem_regwrite (mem_regwrite_r),
        .mem_valid    (mem_valid_r),
        .sel          (fwd_b_s)
    );

    // The MEM access is still outstanding: everything from ID/EX down holds.
    assign freeze_s = mem_valid_r & mem_memop_r & ~bus.dmem_ready;

    // A load in EX whose result a real ID instruction needs cannot be forwarded yet.
    assign load_hazard_s = bus.id_valid & ex_valid_r & ex_memread_r
                         & (ex_rd_r != {REG_ADDR_W{1'b0}})
                         & ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd_r))
                          | (bus.id_use_rs2 & (bus.id_rs2 == ex_rd_r)));

    // The bubble inserted by a load stall leaves EX empty, so no stall can chain.
    assign stall_s  = load_hazard_s & (state_r != LOAD_STALL);

    // The ID instruction does not enter EX on a gap, a branch flush or a stall.
    assign bubble_s = ~bus.id_valid | bus.ex_branch_taken | stall_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a branch discards a coincident load-use stall.
    always_comb begin
        state_nxt_s = RUN;
        case (state_r)
            RUN, MEM_WAIT, LOAD_STALL: begin
                if (freeze_s) begin
                    state_nxt_s = MEM_WAIT;
                end else if (bus.ex_branch_taken) begin
                    state_nxt_s = RUN;
                end else if (stall_s) begin
                    state_nxt_s = LOAD_STALL;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Output decode in priority order reset > memory wait > branch > load stall.
    always_comb begin
        pc_write_en_s = 1'b1;
        id_ex_flush_s = 1'b0;
        if_id_flush_s = 1'b0;
        pipe_freeze_s = 1'b0;
        if (reset) begin
            pc_write_en_s = 1'b1;
        end else if (freeze_s) begin
            pipe_freeze_s = 1'b1;
            pc_write_en_s = 1'b0;
        end else if (bus.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (stall_s) begin
            pc_write_en_s = 1'b0;
            id_ex_flush_s = 1'b1;
        end else begin
            pc_write_en_s = 1'b1;
        end
    end

    // Metadata shift and registered operand selects; everything holds while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r     <= 1'b0;
            ex_regwrite_r  <= 1'b0;
            ex_memread_r   <= 1'b0;
            ex_memop_r     <= 1'b0;
            ex_rd_r        <= {REG_ADDR_W{1'b0}};
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memop_r    <= 1'b0;
            mem_rd_r       <= {REG_ADDR_W{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_regwrite_r  <= 1'b0;
            wb_rd_r        <= {REG_ADDR_W{1'b0}};
            fwd_a_r        <= FWD_RF;
            fwd_b_r        <= FWD_RF;
        end else if (!freeze_s) begin
            wb_valid_r     <= mem_valid_r;
            wb_regwrite_r  <= mem_regwrite_r;
            wb_rd_r        <= mem_rd_r;
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_regwrite_r;
            mem_memop_r    <= ex_memop_r;
            mem_rd_r       <= ex_rd_r;
            if (bubble_s) begin
                ex_valid_r    <= 1'b0;
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_memop_r    <= 1'b0;
                ex_rd_r       <= {REG_ADDR_W{1'b0}};
                fwd_a_r       <= FWD_RF;
                fwd_b_r       <= FWD_RF;
            end else begin
                ex_valid_r    <= 1'b1;
                ex_regwrite_r <= bus.id_regwrite;
                ex_memread_r  <= bus.id_memread;
                ex_memop_r    <= bus.id_memop;
                ex_rd_r       <= bus.id_rd;
                fwd_a_r       <= fwd_a_s;
                fwd_b_r       <= fwd_b_s;
            end
        end else begin
            ex_valid_r     <= ex_valid_r;
            mem_valid_r    <= mem_valid_r;
            wb_valid_r     <= wb_valid_r;
            fwd_a_r        <= fwd_a_r;
            fwd_b_r        <= fwd_b_r;
        end
    end

    assign bus.fwd_a_sel   = fwd_a_r;
    assign bus.fwd_b_sel   = fwd_b_r;
    assign bus.pc_write_en = pc_write_en_s;
    assign bus.id_ex_flush = id_ex_flush_s;
    assign bus.if_id_flush = if_id_flush_s;
    assign bus.pipe_freeze = pipe_freeze_s;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count every cycle the front end is held, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_write_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    // The counter width only matters when statistics are built in.
    logic [CNT_W-1:0] unused_cnt_s;
    assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule
